seq_det_ctrl: RTL and testbench

- Single-clock controller that schedules and configures serial pattern detection.
- A programmable clock-enable divider generates the sample strobe; no derived clocks are used.
- A configurable pattern matcher (pattern, length, overlap mode) runs on each strobe and counts matches up to a target.
- Sits between the register/config interface and the serial input; `done` and `match` feed the interrupt logic.

---
 rtl/seq_det_pkg.sv | 22 ++
 rtl/clk_en_div.sv | 28 ++
 rtl/seq_det_ctrl.sv | 162 ++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared state encoding, reset-time configuration and the length-mask helper
// used by the serial pattern detection controller.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_DIV    = 0;
    localparam int DEF_PAT    = 0;
    localparam int DEF_LEN    = 1;
    localparam int DEF_OVL    = 1;
    localparam int DEF_TARGET = 0;

    // One bit of the compare mask: bit idx takes part in the match when idx < len.
    function automatic logic len_mask_bit(input int idx, input int len);
        return (idx < len);
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: stb is high for one clock every div+1 clocks while en.
// Used instead of derived clocks so everything stays on clk.
module clk_en_div #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             stb
);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (clr) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == div) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    assign stb = en && (div_cnt == div);

endmodule

// File: rtl/seq_det_ctrl.sv
// Serial pattern detection controller: config registers, IDLE/RUN/DONE FSM,
// strobed shift-register matcher and saturating match counter.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int DIV_W   = 4,
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_we,
    input  logic [DIV_W-1:0]               cfg_div,
    input  logic [PAT_MAX-1:0]             cfg_pat,
    input  logic [$clog2(PAT_MAX+1)-1:0]   cfg_len,
    input  logic                           cfg_ovl,
    input  logic [CNT_W-1:0]               cfg_target,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           ser_in,
    output logic                           sample_stb,
    output logic                           match,
    output logic [CNT_W-1:0]               match_cnt,
    output logic                           busy,
    output logic                           done,
    output logic                           cfg_err
);

    localparam int LEN_W = $clog2(PAT_MAX + 1);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] DONE = ST_DONE;

    // Control interface contract: start, abort and cfg_we are single-cycle
    // requests with no back-pressure; abort beats start, a config write in the
    // same cycle as start lands first, and outcomes come back as one-cycle
    // pulses (match, cfg_err) or levels (busy, done) one clock later.

    logic [1:0]         state;
    logic [DIV_W-1:0]   div_r;
    logic [PAT_MAX-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic               ovl_r;
    logic [CNT_W-1:0]   target_r;

    logic [PAT_MAX-1:0] shift_r;
    logic [LEN_W-1:0]   fill_r;
    logic               match_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               cfg_err_r;

    logic               in_run;
    logic               cfg_len_ok;
    logic               cfg_ok;
    logic               start_go;
    logic               div_stb;
    logic               strobe;
    logic [PAT_MAX-1:0] shift_nxt;
    logic [LEN_W-1:0]   fill_nxt;
    logic [PAT_MAX-1:0] mask;
    logic               hit;
    logic [CNT_W-1:0]   cnt_inc;
    logic               last_hit;

    assign in_run     = (state == RUN);
    assign cfg_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_MAX));
    assign cfg_ok     = cfg_we && !in_run && cfg_len_ok;
    assign start_go   = start && !abort && !in_run;

    clk_en_div #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .en  (in_run),
        .clr (start_go || abort),
        .div (div_r),
        .stb (div_stb)
    );

    // A strobe landing in the abort cycle is dropped so no match can follow it.
    assign strobe = div_stb && !abort;

    for (genvar i = 0; i < PAT_MAX; i++) begin : g_mask
        assign mask[i] = len_mask_bit(i, int'(len_r));
    end

    assign shift_nxt = {shift_r[PAT_MAX-2:0], ser_in};
    assign fill_nxt  = (fill_r == LEN_W'(PAT_MAX)) ? fill_r : fill_r + LEN_W'(1);
    assign hit       = (fill_nxt >= len_r) && (((shift_nxt ^ pat_r) & mask) == '0);
    assign cnt_inc   = (&cnt_r) ? cnt_r : cnt_r + CNT_W'(1);
    assign last_hit  = strobe && hit && (target_r != '0) && (cnt_inc == target_r);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (abort) begin
            state <= IDLE;
        end else if (start_go) begin
            state <= RUN;
        end else if (last_hit) begin
            state <= DONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_r     <= DIV_W'(DEF_DIV);
            pat_r     <= PAT_MAX'(DEF_PAT);
            len_r     <= LEN_W'(DEF_LEN);
            ovl_r     <= 1'(DEF_OVL);
            target_r  <= CNT_W'(DEF_TARGET);
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= cfg_we && !cfg_ok;
            if (cfg_ok) begin
                div_r    <= cfg_div;
                pat_r    <= cfg_pat;
                len_r    <= cfg_len;
                ovl_r    <= cfg_ovl;
                target_r <= cfg_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_r <= '0;
            fill_r  <= '0;
            match_r <= 1'b0;
            cnt_r   <= '0;
        end else if (abort) begin
            shift_r <= '0;
            fill_r  <= '0;
            match_r <= 1'b0;
        end else if (start_go) begin
            shift_r <= '0;
            fill_r  <= '0;
            match_r <= 1'b0;
            cnt_r   <= '0;
        end else if (strobe) begin
            shift_r <= shift_nxt;
            // Without overlap a match consumes its bits: the next one needs len fresh samples.
            fill_r  <= (hit && !ovl_r) ? '0 : fill_nxt;
            match_r <= hit;
            if (hit) begin
                cnt_r <= cnt_inc;
            end
        end else begin
            match_r <= 1'b0;
        end
    end

    assign sample_stb = div_stb;
    assign match      = match_r;
    assign match_cnt  = cnt_r;
    assign busy       = in_run;
    assign done       = (state == DONE);
    assign cfg_err    = cfg_err_r;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl: divider timing, overlap and
// non-overlap counting, target completion, abort, config rejection and reset.
module tb_seq_det_ctrl;

    localparam int DIV_W   = 4;
    localparam int PAT_MAX = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cfg_we = 1'b0;
    logic [DIV_W-1:0]   cfg_div = '0;
    logic [PAT_MAX-1:0] cfg_pat = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_ovl = 1'b0;
    logic [CNT_W-1:0]   cfg_target = '0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               ser_in = 1'b0;
    logic               sample_stb;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy;
    logic               done;
    logic               cfg_err;

    int checks = 0;
    int errors = 0;

    logic stream_bits [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic ovl_match   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int   ovl_cnt     [7] = '{0, 0, 0, 1, 1, 1, 2};
    logic novl_match  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int   novl_cnt    [7] = '{0, 0, 0, 1, 1, 1, 1};
    logic one_bits    [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int   one_cnt     [7] = '{1, 2, 2, 3, 3, 3, 4};

    seq_det_ctrl #(
        .DIV_W   (DIV_W),
        .PAT_MAX (PAT_MAX),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_div    (cfg_div),
        .cfg_pat    (cfg_pat),
        .cfg_len    (cfg_len),
        .cfg_ovl    (cfg_ovl),
        .cfg_target (cfg_target),
        .start      (start),
        .abort      (abort),
        .ser_in     (ser_in),
        .sample_stb (sample_stb),
        .match      (match),
        .match_cnt  (match_cnt),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [DIV_W-1:0] d, input logic [PAT_MAX-1:0] p,
                             input logic [LEN_W-1:0] l, input logic o,
                             input logic [CNT_W-1:0] t, input logic with_start);
        cfg_div    = d;
        cfg_pat    = p;
        cfg_len    = l;
        cfg_ovl    = o;
        cfg_target = t;
        cfg_we     = 1'b1;
        start      = with_start;
        tick();
        cfg_we     = 1'b0;
        start      = 1'b0;
    endtask

    // Hold the bit until a strobe is up, let that edge sample it, then check match.
    task automatic send_bit(input logic b, input logic exp_match, input string tag);
        int n;
        n = 0;
        ser_in = b;
        while (!sample_stb && n < 20) begin
            tick();
            n++;
        end
        chk("stb_wait", sample_stb, 1);
        tick();
        chk(tag, match, exp_match);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        int n_stb;

        repeat (3) tick();
        chk("rst_stb", sample_stb, 0);
        chk("rst_match", match, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        rst = 1'b1;
        tick();

        // Divider timing with div=2 and an all-zero stream
        cfg_write(4'd2, 8'h0B, 4'd4, 1'b1, 8'd0, 1'b0);
        chk("s1_cfg_ok", cfg_err, 0);
        ser_in = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("s1_busy", busy, 1);
        for (int k = 0; k < 9; k++) begin
            chk("s1_stb", sample_stb, (k % 3 == 2) ? 1 : 0);
            chk("s1_match", match, 0);
            tick();
        end
        do_abort();
        chk("s1_abort_busy", busy, 0);

        // Overlapping matches
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s2_cnt_clr", match_cnt, 0);
        for (int i = 0; i < 7; i++) begin
            send_bit(stream_bits[i], ovl_match[i], "s2_match");
            chk("s2_cnt", match_cnt, ovl_cnt[i]);
        end
        chk("s2_busy", busy, 1);
        do_abort();
        chk("s5_abort_busy", busy, 0);
        chk("s5_abort_done", done, 0);
        chk("s5_abort_cnt_hold", match_cnt, 2);
        chk("s5_abort_no_match", match, 0);

        // Non-overlapping matches
        cfg_write(4'd2, 8'h0B, 4'd4, 1'b0, 8'd0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s3_cnt_clr", match_cnt, 0);
        for (int i = 0; i < 7; i++) begin
            send_bit(stream_bits[i], novl_match[i], "s3_match");
            chk("s3_cnt", match_cnt, novl_cnt[i]);
        end
        do_abort();

        // Target of 2, config written in the same cycle as start
        cfg_write(4'd2, 8'h0B, 4'd4, 1'b1, 8'd2, 1'b1);
        chk("s4_busy", busy, 1);
        chk("s4_cnt_clr", match_cnt, 0);
        for (int i = 0; i < 7; i++) begin
            send_bit(stream_bits[i], ovl_match[i], "s4_match");
            chk("s4_cnt", match_cnt, ovl_cnt[i]);
        end
        chk("s4_done", done, 1);
        chk("s4_busy_low", busy, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("s4_stb_stopped", sample_stb, 0);
            chk("s4_done_hold", done, 1);
            chk("s4_cnt_hold", match_cnt, 2);
        end

        // Config write attempted during RUN must be rejected
        ser_in = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("s5_restart_busy", busy, 1);
        chk("s5_restart_done", done, 0);
        cfg_div = 4'd0;
        cfg_pat = 8'h01;
        cfg_len = 4'd1;
        cfg_we  = 1'b1;
        tick();
        cfg_we  = 1'b0;
        chk("s5_run_cfg_err", cfg_err, 1);
        tick();
        chk("s5_cfg_err_pulse", cfg_err, 0);
        n_stb = int'(sample_stb);
        repeat (5) begin
            tick();
            n_stb += int'(sample_stb);
        end
        chk("s5_div_kept", n_stb, 2);
        do_abort();

        // Illegal lengths in IDLE
        cfg_write(4'd0, 8'h01, 4'd0, 1'b1, 8'd0, 1'b0);
        chk("s5_len0_err", cfg_err, 1);
        cfg_write(4'd0, 8'h01, 4'd9, 1'b1, 8'd0, 1'b0);
        chk("s5_len9_err", cfg_err, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s5_bad_cfg_kept", sample_stb, 0);
        do_abort();

        // start and abort together stay in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("s6_prio_busy", busy, 0);
        chk("s6_prio_done", done, 0);

        // div=0, single-bit pattern 1
        cfg_write(4'd0, 8'h01, 4'd1, 1'b1, 8'd0, 1'b1);
        chk("s6_stb_every", sample_stb, 1);
        for (int i = 0; i < 7; i++) begin
            send_bit(one_bits[i], one_bits[i], "s6_match");
            chk("s6_cnt", match_cnt, one_cnt[i]);
        end

        // Asynchronous reset in the middle of a run
        ser_in = 1'b1;
        tick();
        chk("s6_pre_rst_match", match, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("s6_rst_stb", sample_stb, 0);
        chk("s6_rst_match", match, 0);
        chk("s6_rst_cnt", match_cnt, 0);
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_done", done, 0);
        chk("s6_rst_cfg_err", cfg_err, 0);
        #2;
        rst = 1'b1;
        tick();
        chk("s6_post_rst_busy", busy, 0);
        chk("s6_post_rst_match", match, 0);

        // Reset config is div=0, pat=0, len=1: every 0 bit matches
        ser_in = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("def_stb", sample_stb, 1);
        tick();
        chk("def_match", match, 1);
        chk("def_cnt", match_cnt, 1);
        do_abort();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
